dual_port_ram_ctrl: RTL and testbench

Parametrised true dual-port synchronous RAM, the next generation of the team's 8x64 dual-port RAM. It adds width/depth parameters, per-port enables and byte enables, a selectable read-during-write mode, an optional output pipeline stage with read-valid flags, and deterministic write-collision arbitration with a sticky collision flag. It sits between two independent masters (e.g. DMA and CPU-side logic) in the same clock domain.

---
 rtl/dpr_pkg.sv | 16 +
 rtl/dpr_port_out.sv | 76 +++++++
 rtl/dual_port_ram_ctrl.sv | 127 ++++++++++++
 tb/tb_dual_port_ram_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpr_pkg.sv
// Shared definitions for the dual-port RAM controller: read-during-write mode
// encodings and the byte-lane merge helper.
package dpr_pkg;

    localparam int RDW_NO_CHANGE   = 0;
    localparam int RDW_READ_FIRST  = 1;
    localparam int RDW_WRITE_FIRST = 2;

    // One byte lane of a masked write: the new byte replaces the old one only when enabled.
    function automatic logic [7:0] merge_be(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/dpr_port_out.sv
// Per-port output path: read-during-write selection, optional output register
// stage and the matching read-valid pipeline.
module dpr_port_out
    import dpr_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int RDW_MODE = RDW_NO_CHANGE,
    parameter int OUT_REG  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    output logic [DATA_W-1:0] q,
    output logic              rvalid
);

    logic [DATA_W-1:0] s1_q;
    logic [DATA_W-1:0] s1_q_next;
    logic              s1_valid;
    logic              s1_valid_next;

    // A NO_CHANGE write leaves q untouched and flags no data, like an idle cycle.
    always_comb begin
        s1_q_next     = s1_q;
        s1_valid_next = 1'b0;
        if (en) begin
            if (!we) begin
                s1_q_next     = old_word;
                s1_valid_next = 1'b1;
            end else if (RDW_MODE == RDW_READ_FIRST) begin
                s1_q_next     = old_word;
                s1_valid_next = 1'b1;
            end else if (RDW_MODE == RDW_WRITE_FIRST) begin
                s1_q_next     = new_word;
                s1_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_q     <= s1_q_next;
            s1_valid <= s1_valid_next;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] s2_q;
            logic              s2_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_q     <= '0;
                    s2_valid <= 1'b0;
                end else begin
                    s2_q     <= s1_q;
                    s2_valid <= s1_valid;
                end
            end

            assign q      = s2_q;
            assign rvalid = s2_valid;
        end else begin : g_direct
            assign q      = s1_q;
            assign rvalid = s1_valid;
        end
    endgenerate

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// Parametrised true dual-port RAM with byte enables, read-during-write modes,
// optional output register and deterministic same-address write arbitration.
module dual_port_ram_ctrl
    import dpr_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int RDW_MODE = RDW_NO_CHANGE,
    parameter int OUT_REG  = 0,
    parameter int A_WINS   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_a,
    input  logic                we_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W-1:0]   data_a,
    output logic [DATA_W-1:0]   q_a,
    output logic                rvalid_a,
    input  logic                en_b,
    input  logic                we_b,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   data_b,
    output logic [DATA_W-1:0]   q_b,
    output logic                rvalid_b,
    output logic                collision,
    input  logic                clr_collision
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NB-1:0]     be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            r[8*i +: 8] = merge_be(old_w[8*i +: 8], new_w[8*i +: 8], be[i]);
        end
        return r;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_a;
    logic              wr_b;
    logic              dual_write;
    logic [NB-1:0]     be_a_eff;
    logic [NB-1:0]     be_b_eff;
    logic [DATA_W-1:0] old_a;
    logic [DATA_W-1:0] old_b;
    logic [DATA_W-1:0] coll_word;
    logic [DATA_W-1:0] new_a;
    logic [DATA_W-1:0] new_b;

    assign wr_a       = en_a & we_a;
    assign wr_b       = en_b & we_b;
    assign dual_write = wr_a & wr_b & (addr_a == addr_b);

    // The losing port only fills lanes the winner left alone, so the lane sets are disjoint.
    assign be_a_eff = (dual_write && A_WINS == 0) ? (be_a & ~be_b) : be_a;
    assign be_b_eff = (dual_write && A_WINS != 0) ? (be_b & ~be_a) : be_b;

    assign old_a     = mem[addr_a];
    assign old_b     = mem[addr_b];
    assign coll_word = merge_word(merge_word(old_a, data_a, be_a_eff), data_b, be_b_eff);
    assign new_a     = dual_write ? coll_word : merge_word(old_a, data_a, be_a);
    assign new_b     = dual_write ? coll_word : merge_word(old_b, data_b, be_b);

    // The array has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (dual_write) begin
            mem[addr_a] <= coll_word;
        end else begin
            if (wr_a) begin
                mem[addr_a] <= new_a;
            end
            if (wr_b) begin
                mem[addr_b] <= new_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision <= 1'b0;
        end else if (dual_write) begin
            collision <= 1'b1;
        end else if (clr_collision) begin
            collision <= 1'b0;
        end
    end

    dpr_port_out #(
        .DATA_W   (DATA_W),
        .RDW_MODE (RDW_MODE),
        .OUT_REG  (OUT_REG)
    ) u_out_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en_a),
        .we       (we_a),
        .old_word (old_a),
        .new_word (new_a),
        .q        (q_a),
        .rvalid   (rvalid_a)
    );

    dpr_port_out #(
        .DATA_W   (DATA_W),
        .RDW_MODE (RDW_MODE),
        .OUT_REG  (OUT_REG)
    ) u_out_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en_b),
        .we       (we_b),
        .old_word (old_b),
        .new_word (new_b),
        .q        (q_b),
        .rvalid   (rvalid_b)
    );

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Bench for dual_port_ram_ctrl: three configurations share one stimulus stream
// and are compared every cycle against a word/byte-level reference model.
module tb_dual_port_ram_ctrl;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int NCFG = 3;
    localparam int RDW  [NCFG] = '{0, 1, 2};
    localparam int OREG [NCFG] = '{0, 1, 0};
    localparam int AWIN [NCFG] = '{1, 1, 0};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_a, we_a, en_b, we_b, clr_collision;
    logic [1:0]    be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;

    logic [DW-1:0] q_a_o      [NCFG];
    logic [DW-1:0] q_b_o      [NCFG];
    logic          rvalid_a_o [NCFG];
    logic          rvalid_b_o [NCFG];
    logic          coll_o     [NCFG];

    int checks   = 0;
    int failures = 0;

    // Reference state: memory image plus the latest and one-cycle-older port results.
    logic [DW-1:0] mm      [NCFG][2**AW];
    logic [DW-1:0] cur_qa  [NCFG], prev_qa [NCFG], cur_qb [NCFG], prev_qb [NCFG];
    logic          cur_va  [NCFG], prev_va [NCFG], cur_vb [NCFG], prev_vb [NCFG];
    logic          coll_m  [NCFG];

    always #5 clk = ~clk;

    dual_port_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .OUT_REG(0), .A_WINS(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(q_a_o[0]), .rvalid_a(rvalid_a_o[0]),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(q_b_o[0]), .rvalid_b(rvalid_b_o[0]),
        .collision(coll_o[0]), .clr_collision(clr_collision));

    dual_port_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .OUT_REG(1), .A_WINS(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(q_a_o[1]), .rvalid_a(rvalid_a_o[1]),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(q_b_o[1]), .rvalid_b(rvalid_b_o[1]),
        .collision(coll_o[1]), .clr_collision(clr_collision));

    dual_port_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(2), .OUT_REG(0), .A_WINS(0)) u2 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(q_a_o[2]), .rvalid_a(rvalid_a_o[2]),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(q_b_o[2]), .rvalid_b(rvalid_b_o[2]),
        .collision(coll_o[2]), .clr_collision(clr_collision));

    task automatic check(input string tag, input int c, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s u%0d observed=%h expected=%h at %0t", tag, c, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < NCFG; c++) begin
            cur_qa[c] = '0; prev_qa[c] = '0; cur_qb[c] = '0; prev_qb[c] = '0;
            cur_va[c] = 1'b0; prev_va[c] = 1'b0; cur_vb[c] = 1'b0; prev_vb[c] = 1'b0;
            coll_m[c] = 1'b0;
        end
    endtask

    // Applies one clock edge of the current inputs to the reference model.
    task automatic modelStep();
        logic [DW-1:0] oa, ob, w;
        logic          wra, wrb;
        for (int c = 0; c < NCFG; c++) begin
            oa  = mm[c][addr_a];
            ob  = mm[c][addr_b];
            wra = en_a && we_a;
            wrb = en_b && we_b;
            if (wra && wrb && addr_a == addr_b) begin
                w = oa;
                for (int i = 0; i < 2; i++) begin
                    if (AWIN[c] != 0) begin
                        if (be_a[i])      w[8*i +: 8] = data_a[8*i +: 8];
                        else if (be_b[i]) w[8*i +: 8] = data_b[8*i +: 8];
                    end else begin
                        if (be_b[i])      w[8*i +: 8] = data_b[8*i +: 8];
                        else if (be_a[i]) w[8*i +: 8] = data_a[8*i +: 8];
                    end
                end
                mm[c][addr_a] = w;
                coll_m[c] = 1'b1;
            end else begin
                if (wra) begin
                    w = oa;
                    for (int i = 0; i < 2; i++) if (be_a[i]) w[8*i +: 8] = data_a[8*i +: 8];
                    mm[c][addr_a] = w;
                end
                if (wrb) begin
                    w = ob;
                    for (int i = 0; i < 2; i++) if (be_b[i]) w[8*i +: 8] = data_b[8*i +: 8];
                    mm[c][addr_b] = w;
                end
                if (clr_collision) coll_m[c] = 1'b0;
            end
            prev_qa[c] = cur_qa[c]; prev_va[c] = cur_va[c];
            prev_qb[c] = cur_qb[c]; prev_vb[c] = cur_vb[c];
            cur_va[c] = 1'b0;
            if (en_a) begin
                if (!we_a)              begin cur_qa[c] = oa;            cur_va[c] = 1'b1; end
                else if (RDW[c] == 1)   begin cur_qa[c] = oa;            cur_va[c] = 1'b1; end
                else if (RDW[c] == 2)   begin cur_qa[c] = mm[c][addr_a]; cur_va[c] = 1'b1; end
            end
            cur_vb[c] = 1'b0;
            if (en_b) begin
                if (!we_b)              begin cur_qb[c] = ob;            cur_vb[c] = 1'b1; end
                else if (RDW[c] == 1)   begin cur_qb[c] = ob;            cur_vb[c] = 1'b1; end
                else if (RDW[c] == 2)   begin cur_qb[c] = mm[c][addr_b]; cur_vb[c] = 1'b1; end
            end
        end
    endtask

    task automatic checkOutput();
        for (int c = 0; c < NCFG; c++) begin
            check("q_a",       c, q_a_o[c],           (OREG[c] != 0) ? prev_qa[c] : cur_qa[c]);
            check("rvalid_a",  c, 16'(rvalid_a_o[c]), 16'((OREG[c] != 0) ? prev_va[c] : cur_va[c]));
            check("q_b",       c, q_b_o[c],           (OREG[c] != 0) ? prev_qb[c] : cur_qb[c]);
            check("rvalid_b",  c, 16'(rvalid_b_o[c]), 16'((OREG[c] != 0) ? prev_vb[c] : cur_vb[c]));
            check("collision", c, 16'(coll_o[c]),     16'(coll_m[c]));
        end
    endtask

    task automatic applyStimulus(input logic ea, input logic wa, input logic [1:0] ba,
                                 input logic [AW-1:0] aa, input logic [DW-1:0] da,
                                 input logic eb, input logic wb, input logic [1:0] bb,
                                 input logic [AW-1:0] ab, input logic [DW-1:0] db,
                                 input logic clr, input logic do_check);
        @(negedge clk);
        en_a = ea; we_a = wa; be_a = ba; addr_a = aa; data_a = da;
        en_b = eb; we_b = wb; be_b = bb; addr_b = ab; data_b = db;
        clr_collision = clr;
        @(posedge clk);
        #1;
        modelStep();
        if (do_check) checkOutput();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 2'b00, '0, '0, 0, 0, 2'b00, '0, '0, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 0; we_a = 0; be_a = '0; addr_a = '0; data_a = '0;
        en_b = 0; we_b = 0; be_b = '0; addr_b = '0; data_b = '0;
        clr_collision = 0;
        modelReset();
        #12;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the whole array so every later read has a defined reference.
        for (int i = 0; i < 32; i++)
            applyStimulus(1, 1, 2'b11, 6'(2*i), 16'($urandom),
                          1, 1, 2'b11, 6'(2*i+1), 16'($urandom), 0, 0);
        applyStimulus(1, 0, 2'b00, 6'd0, '0, 1, 0, 2'b00, 6'd1, '0, 0, 0);
        applyStimulus(1, 0, 2'b00, 6'd2, '0, 1, 0, 2'b00, 6'd3, '0, 0, 0);
        checkOutput();

        // Byte-enable merge.
        applyStimulus(1, 1, 2'b11, 6'd5, 16'hAAAA, 0, 0, 2'b00, '0, '0, 0, 1);
        applyStimulus(1, 1, 2'b01, 6'd5, 16'h1234, 0, 0, 2'b00, '0, '0, 0, 1);
        applyStimulus(0, 0, 2'b00, '0, '0, 1, 0, 2'b00, 6'd5, '0, 0, 1);
        check("be_merge", 0, q_b_o[0], 16'hAA34);
        check("be_merge_rvalid", 0, 16'(rvalid_b_o[0]), 16'd1);

        // Same-port read-during-write in each mode.
        applyStimulus(1, 1, 2'b11, 6'd3, 16'h0011, 0, 0, 2'b00, '0, '0, 0, 1);
        applyStimulus(1, 0, 2'b00, 6'd3, '0, 0, 0, 2'b00, '0, '0, 0, 1);
        applyStimulus(1, 1, 2'b11, 6'd3, 16'h0022, 0, 0, 2'b00, '0, '0, 0, 1);
        check("rdw0_hold", 0, q_a_o[0], 16'h0011);
        check("rdw0_rvalid", 0, 16'(rvalid_a_o[0]), 16'd0);
        check("rdw2_new", 2, q_a_o[2], 16'h0022);
        idle();
        check("rdw1_old", 1, q_a_o[1], 16'h0011);
        applyStimulus(1, 0, 2'b00, 6'd3, '0, 0, 0, 2'b00, '0, '0, 0, 1);
        check("rdw_mem", 0, q_a_o[0], 16'h0022);

        // Cross-port write versus read on the same address.
        applyStimulus(1, 1, 2'b11, 6'd9, 16'h000F, 0, 0, 2'b00, '0, '0, 0, 1);
        applyStimulus(1, 1, 2'b11, 6'd9, 16'h005A, 1, 0, 2'b00, 6'd9, '0, 0, 1);
        check("cross_old", 0, q_b_o[0], 16'h000F);
        check("cross_old_wf", 2, q_b_o[2], 16'h000F);
        applyStimulus(0, 0, 2'b00, '0, '0, 1, 0, 2'b00, 6'd9, '0, 0, 1);
        check("cross_new", 0, q_b_o[0], 16'h005A);

        // Write collision, sticky flag and clear priority.
        applyStimulus(1, 1, 2'b11, 6'd7, 16'h00C3, 1, 1, 2'b11, 6'd7, 16'h003C, 0, 1);
        check("coll_set", 0, 16'(coll_o[0]), 16'd1);
        applyStimulus(1, 0, 2'b00, 6'd7, '0, 1, 0, 2'b00, 6'd7, '0, 0, 1);
        check("coll_a_wins", 0, q_a_o[0], 16'h00C3);
        check("coll_b_wins", 2, q_b_o[2], 16'h003C);
        applyStimulus(0, 0, 2'b00, '0, '0, 0, 0, 2'b00, '0, '0, 1, 1);
        check("coll_clear", 0, 16'(coll_o[0]), 16'd0);
        applyStimulus(1, 1, 2'b01, 6'd8, 16'h1111, 1, 1, 2'b11, 6'd8, 16'h2222, 1, 1);
        check("coll_set_over_clr", 0, 16'(coll_o[0]), 16'd1);
        applyStimulus(0, 0, 2'b00, '0, '0, 0, 0, 2'b00, '0, '0, 1, 1);

        // Asynchronous reset in the middle of pipelined reads.
        applyStimulus(1, 0, 2'b00, 6'd11, '0, 1, 0, 2'b00, 6'd10, '0, 0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        en_a = 0; en_b = 0; we_a = 0; we_b = 0; clr_collision = 0;
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back reads across the whole array on both ports.
        for (int i = 0; i < 64; i++)
            applyStimulus(1, 0, 2'b00, 6'(i), '0, 1, 0, 2'b00, 6'(63 - i), '0, 0, 1);

        // Random traffic on a narrow address window to provoke collisions.
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), 6'($urandom_range(0, 7)), 16'($urandom),
                          1'($urandom), 1'($urandom), 2'($urandom), 6'($urandom_range(0, 7)), 16'($urandom),
                          ($urandom_range(0, 7) == 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
